// File: rtl/audio_sample_scheduler.sv
// Paces buffered stereo sample pairs into the HDMI audio port on a fractional-accumulator audio clock.
// Optional: define AUDIO_SCHED_MUTE_ON_UNDERRUN_EN to output silence instead of repeating on underrun.
module audio_sample_scheduler #(
  parameter int unsigned CLK_HZ    = 30000000,
  parameter int unsigned SAMPLE_HZ = 48000,
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_left,
  input  logic [WIDTH-1:0]         in_right,
  output logic                     audio_clk,
  output logic [2*WIDTH-1:0]       sample_word,
  output logic                     sample_strobe,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underrun,
  output logic [15:0]              underrun_count,
  input  logic                     clear_underrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [32:0] STEP  = 33'(2 * SAMPLE_HZ);
  localparam logic [32:0] LIMIT = 33'(CLK_HZ);

  logic [31:0]        r_acc;
  logic               r_audioClk;
  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wrPtr;
  logic [AW-1:0]      r_rdPtr;
  logic [LW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_sampleWord;
  logic               r_strobe;
  logic               r_underrun;
  logic [15:0]        r_underrunCount;

  logic [32:0] w_sum;
  logic        w_toggle;
  logic        w_popEvent;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_underrunEvent;

  // One extra bit keeps acc+STEP from wrapping before the compare against CLK_HZ.
  assign w_sum           = {1'b0, r_acc} + STEP;
  assign w_toggle        = enable && (w_sum >= LIMIT);
  assign w_popEvent      = w_toggle && r_audioClk;
  assign w_full          = (r_count == LW'(DEPTH));
  assign w_empty         = (r_count == '0);
  assign w_push          = in_valid && !w_full;
  assign w_pop           = w_popEvent && !w_empty;
  assign w_underrunEvent = w_popEvent && w_empty;

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      r_acc      <= '0;
      r_audioClk <= 1'b0;
    end else if (w_toggle) begin
      r_acc      <= 32'(w_sum - LIMIT);
      r_audioClk <= ~r_audioClk;
    end else begin
      r_acc      <= w_sum[31:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_mem[r_wrPtr] <= {in_left, in_right};
    end
  end

  // The word changes on the audio_clk falling edge so it is stable around the rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sampleWord <= '0;
      r_strobe     <= 1'b0;
    end else begin
      r_strobe <= w_popEvent;
      if (w_pop) begin
        r_sampleWord <= r_mem[r_rdPtr];
`ifdef AUDIO_SCHED_MUTE_ON_UNDERRUN_EN
      end else if (w_underrunEvent) begin
        r_sampleWord <= '0;
`endif
      end
    end
  end

  // A new underrun wins over a clear on the same cycle, leaving a count of one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_underrun      <= 1'b0;
      r_underrunCount <= '0;
    end else if (w_underrunEvent) begin
      r_underrun <= 1'b1;
      if (clear_underrun) begin
        r_underrunCount <= 16'd1;
      end else if (r_underrunCount != 16'hFFFF) begin
        r_underrunCount <= r_underrunCount + 16'd1;
      end
    end else if (clear_underrun) begin
      r_underrun      <= 1'b0;
      r_underrunCount <= '0;
    end
  end

  assign in_ready       = !w_full;
  assign audio_clk      = r_audioClk;
  assign sample_word    = r_sampleWord;
  assign sample_strobe  = r_strobe;
  assign fifo_level     = r_count;
  assign underrun       = r_underrun;
  assign underrun_count = r_underrunCount;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Self-checking bench for audio_sample_scheduler: table-driven FIFO fill, scoreboard of sample words,
// cycle-exact audio clock model, plus a small-rate instance for the fractional pacing case.
module tb_audio_sample_scheduler;

  localparam int PERIOD = 625;
  localparam int HALF   = 313;
  localparam int DEPTH  = 8;
`ifdef AUDIO_SCHED_MUTE_ON_UNDERRUN_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [23:0] left;
    logic [23:0] right;
    logic        expReady;
    int          expLevel;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        inValid;
  logic        clearUnderrun;
  logic [23:0] inLeft;
  logic [23:0] inRight;
  logic        inReady;
  logic        audioClk;
  logic [47:0] sampleWord;
  logic        sampleStrobe;
  logic [3:0]  fifoLevel;
  logic        underrun;
  logic [15:0] underrunCount;

  logic        sEnable;
  logic        sReady;
  logic        sAudioClk;
  logic [47:0] sWord;
  logic        sStrobe;
  logic [3:0]  sLevel;
  logic        sUnder;
  logic [15:0] sCount;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          nEn = 0;
  int          mCount = 0;
  logic [47:0] sbQ[$];
  logic [47:0] mWord = '0;
  logic        mUnder = 1'b0;
  int          mUnderCnt = 0;
  logic        mStrobe = 1'b0;
  int          strobeSeen = 0;
  vec_t        vecs[10];
  int          riseN;
  int          strobeN;
  int          sN;
  int          sLast;
  int          sStrobes;

  always #5 clock = ~clock;

  audio_sample_scheduler dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_valid(inValid), .in_ready(inReady), .in_left(inLeft), .in_right(inRight),
    .audio_clk(audioClk), .sample_word(sampleWord), .sample_strobe(sampleStrobe),
    .fifo_level(fifoLevel), .underrun(underrun), .underrun_count(underrunCount),
    .clear_underrun(clearUnderrun)
  );

  audio_sample_scheduler #(.CLK_HZ(100), .SAMPLE_HZ(3), .WIDTH(24), .DEPTH(8)) dutSmall (
    .clock(clock), .reset(reset), .enable(sEnable),
    .in_valid(1'b0), .in_ready(sReady), .in_left(24'h0), .in_right(24'h0),
    .audio_clk(sAudioClk), .sample_word(sWord), .sample_strobe(sStrobe),
    .fifo_level(sLevel), .underrun(sUnder), .underrun_count(sCount),
    .clear_underrun(1'b0)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    tests++;
    if (actual < lo || actual > hi) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, actual, lo, hi, cyc);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [23:0] left, input logic [23:0] right);
    inValid = valid;
    inLeft  = left;
    inRight = right;
  endtask

  task automatic checkAll();
    checkOutput("sample_strobe", 64'(sampleStrobe), 64'(mStrobe));
    checkOutput("audio_clk", 64'(audioClk), 64'(nEn > 0 && (nEn % PERIOD) >= HALF));
    checkOutput("fifo_level", 64'(fifoLevel), 64'(mCount));
    checkOutput("in_ready", 64'(inReady), 64'(mCount != DEPTH));
    checkOutput("underrun", 64'(underrun), 64'(mUnder));
    checkOutput("underrun_count", 64'(underrunCount), 64'(mUnderCnt));
    checkOutput("sample_word", 64'(sampleWord), 64'(mWord));
  endtask

  // Advance one clock, update the reference model for that edge, then compare at the falling edge.
  task automatic stepCycle();
    int          preCount;
    logic        doPush;
    logic        popEdge;
    logic [47:0] pushWord;
    preCount = mCount;
    doPush   = inValid && (mCount != DEPTH);
    pushWord = {inLeft, inRight};
    @(posedge clock);
    cyc++;
    if (reset) begin
      nEn = 0; mCount = 0; sbQ.delete(); mWord = '0;
      mUnder = 1'b0; mUnderCnt = 0; mStrobe = 1'b0;
    end else begin
      if (enable) nEn++;
      else nEn = 0;
      popEdge = (nEn > 0) && ((nEn % PERIOD) == 0);
      mStrobe = popEdge;
      if (popEdge && preCount > 0) begin
        mWord = sbQ.pop_front();
        mCount--;
      end else if (popEdge && MUTE) begin
        mWord = '0;
      end
      if (popEdge && preCount == 0) begin
        mUnder    = 1'b1;
        mUnderCnt = clearUnderrun ? 1 : ((mUnderCnt == 65535) ? 65535 : mUnderCnt + 1);
      end else if (clearUnderrun) begin
        mUnder    = 1'b0;
        mUnderCnt = 0;
      end
      if (doPush) begin
        sbQ.push_back(pushWord);
        mCount++;
      end
    end
    @(negedge clock);
    checkAll();
    if (sampleStrobe) strobeSeen++;
  endtask

  task automatic waitStrobe(output int atN);
    atN = -1;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      stepCycle();
      if (sampleStrobe) begin
        atN = nEn;
        break;
      end
    end
    if (atN < 0) begin
      tests++; fails++;
      $display("[TB] FAIL strobe_timeout: no strobe within %0d cycles (cycle %0d)", 2 * PERIOD, cyc);
    end
  endtask

  task automatic stepUntilPopEdge();
    for (int i = 0; i < PERIOD + 1; i++) begin
      if (((nEn + 1) % PERIOD) == 0) break;
      stepCycle();
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 24'h000001, 24'h000002, 1'b1, 0};
    vecs[1] = '{1'b1, 24'h000003, 24'h000004, 1'b1, 1};
    vecs[2] = '{1'b1, 24'h000005, 24'h000006, 1'b1, 2};
    vecs[3] = '{1'b1, 24'h000007, 24'h000008, 1'b1, 3};
    vecs[4] = '{1'b1, 24'h000009, 24'h00000A, 1'b1, 4};
    vecs[5] = '{1'b1, 24'h00000B, 24'h00000C, 1'b1, 5};
    vecs[6] = '{1'b1, 24'h00000D, 24'h00000E, 1'b1, 6};
    vecs[7] = '{1'b1, 24'h00AAAA, 24'h00BBBB, 1'b1, 7};
    vecs[8] = '{1'b1, 24'h000011, 24'h000012, 1'b0, 8};
    vecs[9] = '{1'b0, 24'h000000, 24'h000000, 1'b0, 8};

    reset = 1'b1; enable = 1'b0; clearUnderrun = 1'b0; sEnable = 1'b0;
    applyStimulus(1'b0, 24'h0, 24'h0);
    @(negedge clock);
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();
    checkOutput("reset_in_ready", 64'(inReady), 64'd1);
    checkOutput("reset_level", 64'(fifoLevel), 64'd0);
    checkOutput("reset_word", 64'(sampleWord), 64'd0);
    checkOutput("reset_audio_clk", 64'(audioClk), 64'd0);

    // Fill with the generator idle-clocked: the ninth pair must bounce off a full FIFO.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].left, vecs[i].right);
      checkOutput("tbl_in_ready", 64'(inReady), 64'(vecs[i].expReady));
      checkOutput("tbl_fifo_level", 64'(fifoLevel), 64'(vecs[i].expLevel));
      stepCycle();
    end
    applyStimulus(1'b0, 24'h0, 24'h0);

    enable = 1'b1;
    strobeSeen = 0;
    riseN = -1;
    for (int i = 0; i < PERIOD; i++) begin
      stepCycle();
      if (audioClk) begin
        riseN = nEn;
        break;
      end
    end
    checkRange("first_rise", riseN, HALF - 1, HALF + 1);
    waitStrobe(strobeN);
    checkOutput("first_strobe_n", 64'(strobeN), 64'd625);
    checkOutput("pop1_word", 64'(sampleWord), 64'h000001000002);
    checkOutput("pop1_level", 64'(fifoLevel), 64'd7);
    waitStrobe(strobeN);
    checkOutput("second_strobe_n", 64'(strobeN), 64'd1250);
    checkOutput("pop2_word", 64'(sampleWord), 64'h000003000004);
    checkOutput("pop2_level", 64'(fifoLevel), 64'd6);
    waitStrobe(strobeN);
    checkOutput("third_strobe_n", 64'(strobeN), 64'd1875);
    checkOutput("pop3_word", 64'(sampleWord), 64'h000005000006);
    checkOutput("pop3_level", 64'(fifoLevel), 64'd5);
    for (int i = 0; i < 5; i++) waitStrobe(strobeN);
    checkOutput("pop8_word", 64'(sampleWord), 64'h00AAAA00BBBB);
    checkOutput("pop8_level", 64'(fifoLevel), 64'd0);

    waitStrobe(strobeN);
    checkOutput("underrun_word", 64'(sampleWord), MUTE ? 64'd0 : 64'h00AAAA00BBBB);
    checkOutput("underrun_flag", 64'(underrun), 64'd1);
    checkOutput("underrun_count1", 64'(underrunCount), 64'd1);
    for (int i = 0; i < 3; i++) waitStrobe(strobeN);
    checkOutput("underrun_count4", 64'(underrunCount), 64'd4);

    stepUntilPopEdge();
    clearUnderrun = 1'b1;
    stepCycle();
    clearUnderrun = 1'b0;
    checkOutput("clear_vs_new_flag", 64'(underrun), 64'd1);
    checkOutput("clear_vs_new_count", 64'(underrunCount), 64'd1);
    clearUnderrun = 1'b1;
    stepCycle();
    clearUnderrun = 1'b0;
    checkOutput("clear_flag", 64'(underrun), 64'd0);
    checkOutput("clear_count", 64'(underrunCount), 64'd0);

    // Push landing on an empty-FIFO pop edge: underrun reported, no bypass.
    stepUntilPopEdge();
    applyStimulus(1'b1, 24'h0000E1, 24'h0000E2);
    stepCycle();
    applyStimulus(1'b0, 24'h0, 24'h0);
    checkOutput("empty_pushpop_flag", 64'(underrun), 64'd1);
    checkOutput("empty_pushpop_level", 64'(fifoLevel), 64'd1);
    waitStrobe(strobeN);
    checkOutput("empty_pushpop_word", 64'(sampleWord), 64'h0000E10000E2);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 24'(32'h100 + i), 24'(32'h200 + i));
      stepCycle();
    end
    checkOutput("full_level", 64'(fifoLevel), 64'd8);
    stepUntilPopEdge();
    checkOutput("full_ready", 64'(inReady), 64'd0);
    stepCycle();
    applyStimulus(1'b0, 24'h0, 24'h0);
    checkOutput("full_pop_level", 64'(fifoLevel), 64'd7);
    checkOutput("full_pop_word", 64'(sampleWord), 64'h000100000200);

    stepUntilPopEdge();
    applyStimulus(1'b1, 24'h0000D1, 24'h0000D2);
    stepCycle();
    applyStimulus(1'b0, 24'h0, 24'h0);
    checkOutput("pushpop_level", 64'(fifoLevel), 64'd7);

    for (int i = 0; i < 70000; i++) begin
      if (nEn >= 100 * PERIOD) break;
      stepCycle();
    end
    checkOutput("period100_n", 64'(nEn), 64'(100 * PERIOD));
    checkOutput("period100_strobe", 64'(sampleStrobe), 64'd1);
    checkOutput("period100_count", 64'(strobeSeen), 64'd100);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 24'(32'h300 + i), 24'(32'h400 + i));
      stepCycle();
    end
    applyStimulus(1'b0, 24'h0, 24'h0);
    for (int i = 0; i < 300; i++) stepCycle();
    checkOutput("pre_reset_level", 64'(fifoLevel), 64'd3);
    reset = 1'b1; enable = 1'b0;
    applyStimulus(1'b1, 24'h00F00F, 24'h00F00F);
    stepCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 24'h0, 24'h0);
    checkOutput("midreset_audio_clk", 64'(audioClk), 64'd0);
    checkOutput("midreset_word", 64'(sampleWord), 64'd0);
    checkOutput("midreset_strobe", 64'(sampleStrobe), 64'd0);
    checkOutput("midreset_level", 64'(fifoLevel), 64'd0);
    checkOutput("midreset_ready", 64'(inReady), 64'd1);
    checkOutput("midreset_underrun", 64'(underrun), 64'd0);
    checkOutput("midreset_count", 64'(underrunCount), 64'd0);
    enable = 1'b1;
    waitStrobe(strobeN);
    checkOutput("post_reset_strobe_n", 64'(strobeN), 64'd625);

    // Fractional pacing on the small instance: 100 Hz clock, 3 Hz samples.
    enable = 1'b0;
    sEnable = 1'b1;
    sN = 0; sLast = 0; sStrobes = 0;
    for (int i = 0; i < 1100; i++) begin
      if (sStrobes >= 30) break;
      stepCycle();
      sN++;
      if (sStrobe) begin
        checkRange("small_interval", sN - sLast, 33, 34);
        sLast = sN;
        sStrobes++;
      end
    end
    checkOutput("small_strobes", 64'(sStrobes), 64'd30);
    checkOutput("small_span", 64'(sLast), 64'd1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_sample_scheduler.md
Name: audio_sample_scheduler

Overview:
- Paces stereo audio samples into the HDMI transmitter's audio port.
- Buffers L/R sample pairs from the audio generator in a small FIFO, using a valid/ready handshake.
- Derives an exact-average audio sample clock from the system clock with a fractional accumulator, so the rate is exact even when CLK_HZ is not a multiple of 2*SAMPLE_HZ.
- Pops one sample per audio period, holds the HDMI sample word stable around the audio clock's rising edge, and reports underruns.

Parameters:
- CLK_HZ, 30000000: frequency of clock, in Hz.
- SAMPLE_HZ, 48000: audio sample rate, in Hz. Requires 2*SAMPLE_HZ < CLK_HZ.
- WIDTH, 24: bits per channel.
- DEPTH, 8: FIFO entries. Power of two, at least 2.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: runs the audio clock generator.
- in_valid, in, 1: sample pair offered.
- in_ready, out, 1: FIFO can accept a pair. Equals !full.
- in_left, in, WIDTH: left sample.
- in_right, in, WIDTH: right sample.
- audio_clk, out, 1: audio sample clock for the HDMI core; registered.
- sample_word, out, 2*WIDTH: {left, right} sample for the HDMI core.
- sample_strobe, out, 1: one-cycle pulse when sample_word updates.
- fifo_level, out, $clog2(DEPTH)+1: current FIFO occupancy.
- underrun, out, 1: sticky underrun flag.
- underrun_count, out, 16: underrun counter; saturates at 0xFFFF.
- clear_underrun, in, 1: clears underrun and underrun_count.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high. A reset asserted mid-operation takes effect at the next edge, without exception.
  - Reset values: acc=0, audio_clk=0, sample_word=0, sample_strobe=0, FIFO empty, fifo_level=0, in_ready=1, underrun=0, underrun_count=0.
  - Pushes presented on a reset cycle are dropped.
- Accumulator:
  - 32-bit unsigned acc; STEP = 2*SAMPLE_HZ.
  - Each cycle with enable=1: if acc+STEP >= CLK_HZ, then acc <= acc+STEP-CLK_HZ and audio_clk toggles. Otherwise acc <= acc+STEP.
  - With defaults, toggles occur every 312 or 313 cycles, giving a period of exactly 625 cycles.
- Enable low:
  - acc<=0 and audio_clk<=0.
  - No pops and no strobes.
  - FIFO keeps accepting pushes.
- Pop event (the toggle where audio_clk goes 1->0), all on the same edge:
  - sample_strobe<=1 for one cycle.
  - If the FIFO is non-empty: sample_word<=head, and the head is popped.
  - If the FIFO is empty: sample_word holds its previous value, underrun<=1, and underrun_count increments (saturating).
  - Updating on the falling edge keeps sample_word stable for half a period on either side of the audio_clk rising edge.
- First sample timing:
  - The first rising edge after enable presents sample_word=0 (or the word left over from a previous run).
  - The first pop happens on the first falling edge, 625 cycles after enable with defaults.
- Push:
  - A push occurs when in_valid && in_ready.
  - The entry is written on that edge, and fifo_level reflects it the next cycle.
- Simultaneous push and pop:
  - On a non-empty FIFO, both occur and fifo_level is unchanged.
  - On an empty FIFO, there is no bypass: the pop underruns and the push lands.
- Full FIFO: in_ready=0, so no push can occur; a simultaneous pop drops the level to DEPTH-1.
- FIFO ordering: strict FIFO; pointers wrap modulo DEPTH.
- Underrun clear:
  - clear_underrun zeroes underrun and underrun_count.
  - If a new underrun occurs on the same cycle, the result is underrun=1 and underrun_count=1.

Optional Feature:
- Macro: AUDIO_SCHED_MUTE_ON_UNDERRUN_EN.
- Defined: on an underrun pop, sample_word<=0 (silence) instead of holding its value.
- Undefined: sample_word repeats the last sample on underrun.
- Flag and counter behaviour is identical in both cases.

Test Plan:
- Defaults, 4 pairs preloaded, then enable=1:
  - audio_clk rises 313±1 cycles after enable and falls at cycle 625.
  - sample_strobe fires at 625, 1250, 1875, ...
  - The period is exactly 625 cycles over 100 periods.
- Push (L,R) = (0x000001,0x000002), then (0x000003,0x000004), then (0x000005,0x000006):
  - Successive strobes give sample_word = 0x000001000002, then 0x000003000004, then 0x000005000006.
  - fifo_level decrements by 1 per strobe.
- enable=0, 9 pushes with in_valid held:
  - in_ready drops after the 8th push and fifo_level=8.
  - The 9th pair is not stored.
  - Enabling then yields the 8 pairs in order.
- FIFO empty at a pop, holding 0x00AAAA00BBBB:
  - sample_word stays 0x00AAAA00BBBB (0 with the macro defined), underrun=1, underrun_count=1.
  - Three more empty pops give a count of 4.
  - clear_underrun gives 0/0.
- CLK_HZ=100, SAMPLE_HZ=3: strobe intervals are 33 or 34 cycles, and 30 strobes span exactly 1000 cycles.
- Reset asserted mid-period with 3 entries queued: the next cycle shows all reset values, and no strobe occurs until 625 cycles after enable is reasserted.
